btn_debouncer: RTL

BTN_DEBOUNCER -- requirements
Module: btn_debouncer

---
 rtl/btn_debouncer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/btn_debouncer.sv
// Push-button debouncer: 2-flop synchronizer, 4-state accept/reject FSM,
// press/release/auto-repeat strobes and a wrapping press counter, all outputs registered.
module btn_debouncer #(
  parameter int unsigned DB_CYCLES   = 250000,
  parameter int unsigned HOLD_CYCLES = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       repeat_pulse,
  output logic [7:0] press_cnt,
  output logic [1:0] state
);

  localparam int unsigned DB_W   = $clog2(DB_CYCLES);
  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } state_t;

  logic              r_s1;
  logic              r_s2;
  state_t            r_state;
  state_t            w_state_nxt;
  logic [DB_W-1:0]   r_db_cnt;
  logic [DB_W-1:0]   w_db_cnt_nxt;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [HOLD_W-1:0] w_hold_cnt_nxt;
  logic              w_press_evt;
  logic              w_release_evt;
  logic              w_repeat_evt;
  logic              r_level;
  logic              r_press;
  logic              r_release;
  logic              r_repeat;
  logic [7:0]        r_press_cnt;

  // Two-flop synchronizer for the asynchronous button level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= btn;
      r_s2 <= r_s1;
    end
  end

  // State and counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_db_cnt   <= {DB_W{1'b0}};
      r_hold_cnt <= {HOLD_W{1'b0}};
    end else begin
      r_state    <= w_state_nxt;
      r_db_cnt   <= w_db_cnt_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
    end
  end

  // Next-state, counter and strobe-event decode
  always_comb begin
    w_state_nxt    = r_state;
    w_db_cnt_nxt   = r_db_cnt;
    w_hold_cnt_nxt = r_hold_cnt;
    w_press_evt    = 1'b0;
    w_release_evt  = 1'b0;
    w_repeat_evt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_s2) begin
          w_state_nxt  = ST_PRESS_WAIT;
          w_db_cnt_nxt = {DB_W{1'b0}};
        end else begin
          w_state_nxt  = ST_IDLE;
        end
      end
      ST_PRESS_WAIT: begin
        if (!r_s2) begin
          w_state_nxt = ST_IDLE;
        end else if (r_db_cnt == DB_LAST) begin
          w_state_nxt    = ST_PRESSED;
          w_hold_cnt_nxt = {HOLD_W{1'b0}};
          w_press_evt    = 1'b1;
        end else begin
          w_db_cnt_nxt = r_db_cnt + DB_W'(1);
        end
      end
      ST_PRESSED: begin
        if (!r_s2) begin
          w_state_nxt  = ST_RELEASE_WAIT;
          w_db_cnt_nxt = {DB_W{1'b0}};
        end else if (r_hold_cnt == HOLD_LAST) begin
          w_hold_cnt_nxt = {HOLD_W{1'b0}};
          w_repeat_evt   = 1'b1;
        end else begin
          w_hold_cnt_nxt = r_hold_cnt + HOLD_W'(1);
        end
      end
      ST_RELEASE_WAIT: begin
        // A level that bounces back high resumes the hold without a new press
        if (r_s2) begin
          w_state_nxt    = ST_PRESSED;
          w_hold_cnt_nxt = {HOLD_W{1'b0}};
        end else if (r_db_cnt == DB_LAST) begin
          w_state_nxt   = ST_IDLE;
          w_release_evt = 1'b1;
        end else begin
          w_db_cnt_nxt = r_db_cnt + DB_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Registered level, strobes and press counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_level     <= 1'b0;
      r_press     <= 1'b0;
      r_release   <= 1'b0;
      r_repeat    <= 1'b0;
      r_press_cnt <= 8'd0;
    end else begin
      r_press   <= w_press_evt;
      r_release <= w_release_evt;
      r_repeat  <= w_repeat_evt;
      if (w_press_evt) begin
        r_level     <= 1'b1;
        r_press_cnt <= r_press_cnt + 8'd1;
      end else if (w_release_evt) begin
        r_level     <= 1'b0;
      end else begin
        r_level     <= r_level;
      end
    end
  end

  assign btn_level     = r_level;
  assign press_pulse   = r_press;
  assign release_pulse = r_release;
  assign repeat_pulse  = r_repeat;
  assign press_cnt     = r_press_cnt;
  assign state         = r_state;

endmodule
